// File: rtl/rvx_uart_debug_master.sv
// UART-driven debug bus master: 'W'/'R' command frames become single bus transactions, with replies sent back over uart_tx.
// Optional bus-response timeout is enabled by defining RVX_UART_DEBUG_MASTER_TIMEOUT_EN.
//
// state      | meaning
// S_IDLE     | waiting for a command byte
// S_ADDR     | collecting 4 address bytes, MSB first
// S_DATA     | collecting 4 write-data bytes, MSB first
// S_BUS_REQ  | one-cycle request strobe
// S_BUS_WAIT | waiting for the matching bus response
// S_REPLY    | shifting reply bytes out on uart_tx
module rvx_uart_debug_master #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUD_RATE  = 115200,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] rw_address,
    output logic [31:0] write_data,
    output logic        write_request,
    input  logic        write_response,
    output logic        read_request,
    input  logic [31:0] read_data,
    input  logic        read_response,
    output logic        busy
);
    localparam int CPB  = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS_REQ, S_BUS_WAIT, S_REPLY} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_BREAK} rx_state_t;

    rx_state_t   rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_valid_q;

    state_t      state_q;
    logic        is_write_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] rw_address_q;
    logic [31:0] write_data_q;
    logic        write_request_q;
    logic        read_request_q;
    logic        busy_q;
    logic        uart_tx_q;
    logic [8:0]  tx_shift_q;
    logic [3:0]  tx_bit_q;
    logic [CW-1:0] tx_cnt_q;
    logic [31:0] reply_q;
    logic [2:0]  reply_left_q;
`ifdef RVX_UART_DEBUG_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;
`endif

    // Receiver; after a framing error the line must return high before a new start is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!uart_rx) begin
                        if (rx_cnt_q == CW'(HALF - 1)) begin
                            rx_state_q <= RX_BITS;
                            rx_cnt_q   <= CW'(CPB - 1);
                            rx_bit_q   <= '0;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= '0;
                    end
                end
                RX_BITS: begin
                    if (rx_cnt_q == '0) begin
                        rx_cnt_q <= CW'(CPB - 1);
                        if (rx_bit_q == 4'd8) begin
                            rx_cnt_q <= '0;
                            if (uart_rx) begin
                                rx_valid_q <= 1'b1;
                                rx_state_q <= RX_IDLE;
                            end else begin
                                rx_state_q <= RX_BREAK;
                            end
                        end else begin
                            rx_shift_q <= {uart_rx, rx_shift_q[7:1]};
                            rx_bit_q   <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                RX_BREAK: if (uart_rx) rx_state_q <= RX_IDLE;
                default:  rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Entering S_REPLY with tx_bit_q=9/tx_cnt_q=0 makes the first byte load through the same path as the rest.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            is_write_q      <= 1'b0;
            byte_cnt_q      <= '0;
            rw_address_q    <= '0;
            write_data_q    <= '0;
            write_request_q <= 1'b0;
            read_request_q  <= 1'b0;
            busy_q          <= 1'b0;
            uart_tx_q       <= 1'b1;
            tx_shift_q      <= '0;
            tx_bit_q        <= '0;
            tx_cnt_q        <= '0;
            reply_q         <= '0;
            reply_left_q    <= '0;
`ifdef RVX_UART_DEBUG_MASTER_TIMEOUT_EN
            to_cnt_q        <= '0;
`endif
        end else begin
            write_request_q <= 1'b0;
            read_request_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid_q) begin
                        busy_q <= 1'b1;
                        if (rx_shift_q == CMD_W || rx_shift_q == CMD_R) begin
                            is_write_q <= (rx_shift_q == CMD_W);
                            byte_cnt_q <= '0;
                            state_q    <= S_ADDR;
                        end else begin
                            reply_q      <= {NAK, 24'h0};
                            reply_left_q <= 3'd1;
                            tx_bit_q     <= 4'd9;
                            tx_cnt_q     <= '0;
                            state_q      <= S_REPLY;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_valid_q) begin
                        rw_address_q <= {rw_address_q[23:0], rx_shift_q};
                        byte_cnt_q   <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 2'd3) begin
                            if (is_write_q) begin
                                state_q <= S_DATA;
                            end else begin
                                state_q        <= S_BUS_REQ;
                                read_request_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid_q) begin
                        write_data_q <= {write_data_q[23:0], rx_shift_q};
                        byte_cnt_q   <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q         <= S_BUS_REQ;
                            write_request_q <= 1'b1;
                        end
                    end
                end
                S_BUS_REQ: begin
                    state_q <= S_BUS_WAIT;
`ifdef RVX_UART_DEBUG_MASTER_TIMEOUT_EN
                    to_cnt_q <= TW'(TIMEOUT_CYCLES - 1);
`endif
                end
                S_BUS_WAIT: begin
                    if (is_write_q && write_response) begin
                        reply_q      <= {ACK, 24'h0};
                        reply_left_q <= 3'd1;
                        tx_bit_q     <= 4'd9;
                        tx_cnt_q     <= '0;
                        state_q      <= S_REPLY;
                    end else if (!is_write_q && read_response) begin
                        reply_q      <= read_data;
                        reply_left_q <= 3'd4;
                        tx_bit_q     <= 4'd9;
                        tx_cnt_q     <= '0;
                        state_q      <= S_REPLY;
                    end
`ifdef RVX_UART_DEBUG_MASTER_TIMEOUT_EN
                    else if (to_cnt_q == '0) begin
                        reply_q      <= {NAK, 24'h0};
                        reply_left_q <= 3'd1;
                        tx_bit_q     <= 4'd9;
                        tx_cnt_q     <= '0;
                        state_q      <= S_REPLY;
                    end else begin
                        to_cnt_q <= to_cnt_q - 1'b1;
                    end
`endif
                end
                S_REPLY: begin
                    if (tx_cnt_q != '0) begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end else if (tx_bit_q != 4'd9) begin
                        uart_tx_q  <= tx_shift_q[0];
                        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        tx_cnt_q   <= CW'(CPB - 1);
                    end else if (reply_left_q != '0) begin
                        uart_tx_q    <= 1'b0;
                        tx_shift_q   <= {1'b1, reply_q[31:24]};
                        reply_q      <= {reply_q[23:0], 8'h00};
                        reply_left_q <= reply_left_q - 1'b1;
                        tx_bit_q     <= '0;
                        tx_cnt_q     <= CW'(CPB - 1);
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uart_tx       = uart_tx_q;
    assign rw_address    = rw_address_q;
    assign write_data    = write_data_q;
    assign write_request = write_request_q;
    assign read_request  = read_request_q;
    assign busy          = busy_q;
endmodule

// File: doc/rvx_uart_debug_master.md
RVX_UART_DEBUG_MASTER -- requirements
Module: rvx_uart_debug_master

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD_RATE, default 115200, serial bit rate; CYCLES_PER_BAUD = CLOCK_FREQUENCY / UART_BAUD_RATE (integer division).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, bus-response wait limit in clock cycles.
REQ-004 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 uart_rx  input  1  serial command input, 8N1, LSB first, idle high.
REQ-007 uart_tx  output  1  serial reply output, 8N1, LSB first, idle high.
REQ-008 rw_address  output  32  bus address of the current transaction.
REQ-009 write_data  output  32  bus write data.
REQ-010 write_request  output  1  one-cycle write strobe.
REQ-011 write_response  input  1  write completion from the target.
REQ-012 read_request  output  1  one-cycle read strobe.
REQ-013 read_data  input  32  read data, valid in the cycle read_response is high.
REQ-014 read_response  input  1  read completion from the target.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 RX: a low level sampled for CYCLES_PER_BAUD/2 cycles SHALL start a byte; data bits then sampled every CYCLES_PER_BAUD cycles; stop bit sampled the same way; stop bit 0 -> byte discarded (framing error).
REQ-017 Command frame: byte 0x57 ('W') + 4 address bytes + 4 data bytes, or byte 0x52 ('R') + 4 address bytes; multi-byte fields big-endian (MSB first).
REQ-018 FSM states: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, REPLY.
REQ-019 IDLE: 0x57/0x52 -> ADDR (latch command); any other byte -> REPLY sending single byte 0x15 (NAK).
REQ-020 ADDR: shift 4 bytes into rw_address; after 4th -> DATA if write, else BUS_REQ.
REQ-021 DATA: shift 4 bytes into write_data; after 4th -> BUS_REQ.
REQ-022 BUS_REQ: assert write_request or read_request for exactly one cycle; -> BUS_WAIT next cycle.
REQ-023 rw_address and write_data SHALL remain stable from BUS_REQ until BUS_WAIT exits.
REQ-024 BUS_WAIT: write_response (write) -> REPLY with byte 0x06 (ACK); read_response (read) -> capture read_data same cycle, REPLY with 4 bytes MSB first.
REQ-025 Response of the wrong type in BUS_WAIT SHALL be ignored.
REQ-026 Response arriving the cycle after the strobe (1-cycle target latency) SHALL be accepted.
REQ-027 TX: start bit 0, 8 data bits LSB first, stop bit 1, each CYCLES_PER_BAUD cycles; consecutive reply bytes back-to-back with no idle gap.
REQ-028 REPLY: after last stop bit completes -> IDLE.
REQ-029 Bytes received outside IDLE/ADDR/DATA SHALL be discarded; RX sampling continues in all states.
REQ-030 Any request strobe SHALL never be asserted outside BUS_REQ.

Reset
REQ-031 reset_n low SHALL immediately force: state IDLE, uart_tx 1, write_request 0, read_request 0, busy 0, rw_address 0, write_data 0, all counters and shift registers 0.
REQ-032 Reset mid-frame or mid-transaction SHALL abandon it; no strobe or reply byte after reset release until a new frame completes.
REQ-033 Reset deassertion is used as-is; no internal resynchronisation.

Configuration
REQ-034 Macro RVX_UART_DEBUG_MASTER_TIMEOUT_EN defined: BUS_WAIT counts cycles; no response after TIMEOUT_CYCLES cycles -> REPLY with byte 0x15, strobes stay low.
REQ-035 Macro undefined: no timeout counter; BUS_WAIT waits indefinitely.

Verification (CLOCK_FREQUENCY=50000000, UART_BAUD_RATE=5000000 -> 10 cycles/bit)
REQ-036 Send 57 00 00 00 08 DE AD BE EF, target responds next cycle -> one write_request pulse, rw_address=0x00000008, write_data=0xDEADBEEF, reply byte 0x06.
REQ-037 Send 52 00 00 00 04, target returns read_data=0x12345678 -> one read_request pulse, reply 12 34 56 78.
REQ-038 Send 0x41 -> no strobe, reply 0x15, busy returns 0.
REQ-039 With macro, TIMEOUT_CYCLES=16, target silent on read -> reply 0x15 at 16 cycles after strobe; without macro -> busy stays 1, uart_tx stays 1.
REQ-040 Pull reset_n low after 3 address bytes, release, send full read frame -> exactly one read_request with the new address only.
REQ-041 Byte with stop bit 0 in ADDR -> byte ignored; next 4 valid bytes form the address.
